// File: rtl/npu_pkg.sv
// Shared NPU definitions: PE count, data bus width and the bus arbiter state encoding.
// Imported by npu, pe and pe_bus_arbiter so every block agrees on these constants.
package npu_pkg;

    localparam int NUM_PE        = 8;
    localparam int BUS_W         = 32;
    localparam int ARB_MAX_BEATS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOST  = 2'd2,
        ST_TURN  = 2'd3
    } arb_state_e;

    // Round-robin successor of an index in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pe_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at NUM_REQ.
module rr_pick
    import npu_pkg::*;
#(
    parameter int NUM_REQ = NUM_PE,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan the ring starting at ptr and keep the first requester seen.
    always_comb begin
        int  cand;
        logic found;
        cand    = 0;
        found   = 1'b0;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = IDX_W'(cand);
            end else begin
                found = found;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/pe_bus_arbiter.sv
// Shared data bus arbiter: round-robin among PEs with a per-grant beat cap, host priority
// at each arbitration point, and one dead TURN cycle between owners for tristate turnaround.
module pe_bus_arbiter
    import npu_pkg::*;
#(
    parameter int NUM_REQ   = NUM_PE,
    parameter int MAX_BEATS = ARB_MAX_BEATS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         last,
    input  logic                       host_req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       host_gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               host_gnt_q, host_gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               grant_end_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    assign grant_end_s = last[owner_q] || !req[owner_q]
                      || (beat_cnt_q == BEAT_W'(MAX_BEATS - 1));

    // Next-state and next-output decode; outputs are computed for the cycle after the decision.
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        host_gnt_d = 1'b0;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                beat_cnt_d = '0;
                if (host_req) begin
                    state_d    = ST_HOST;
                    host_gnt_d = 1'b1;
                end else if (pick_valid_s) begin
                    state_d           = ST_GRANT;
                    gnt_d[pick_idx_s] = 1'b1;
                    owner_d           = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // The ending beat is still driven; the bus goes dead on the following cycle.
                if (grant_end_s) begin
                    state_d    = ST_TURN;
                    rr_ptr_d   = IDX_W'(wrap_inc(int'(owner_q), NUM_REQ));
                    beat_cnt_d = '0;
                end else begin
                    gnt_d[owner_q] = 1'b1;
                    beat_cnt_d     = beat_cnt_q + BEAT_W'(1);
                end
            end
            ST_HOST: begin
                if (host_req) begin
                    host_gnt_d = 1'b1;
                end else begin
                    state_d = ST_TURN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            host_gnt_q <= 1'b0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            host_gnt_q <= host_gnt_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign host_gnt = host_gnt_q;
    assign owner    = owner_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Self-checking bench for pe_bus_arbiter: directed scenarios plus random traffic,
// compared each cycle against an ownership-level reference model.
module tb_pe_bus_arbiter;

    localparam int N   = 8;
    localparam int MAX = 32;
    localparam int HOST_ID = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         host_req;
    logic [N-1:0] gnt;
    logic         host_gnt;
    logic [2:0]   owner;
    logic         busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: who holds the bus (-1 nobody, 0..7 a PE, 8 the host).
    int cur, ptr, beats, m_owner;
    bit gap;
    logic [N-1:0] prev_gnt;
    logic         prev_hg;

    pe_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .last     (last),
        .host_req (host_req),
        .gnt      (gnt),
        .host_gnt (host_gnt),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lst,
                              input logic hr);
        bit found;
        int p;
        found = 0;
        if (r) begin
            cur = -1; gap = 0; ptr = 0; beats = 0; m_owner = 0;
        end else if (cur >= 0 && cur < N) begin
            beats++;
            if (lst[cur] || !rq[cur] || beats == MAX) begin
                ptr = (cur + 1) % N;
                cur = -1;
                gap = 1;
            end
        end else if (cur == HOST_ID) begin
            if (!hr) begin
                cur = -1;
                gap = 1;
            end
        end else begin
            gap = 0;
            cur = -1;
            if (hr) begin
                cur = HOST_ID;
            end else begin
                for (int k = 0; k < N; k++) begin
                    p = (ptr + k) % N;
                    if (!found && rq[p]) begin
                        found = 1; cur = p; beats = 0; m_owner = p;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lst,
                        input logic hr);
        logic [N-1:0] eg;
        logic         bad;
        rst = r; req = rq; last = lst; host_req = hr;
        @(posedge clk);
        model_step(r, rq, lst, hr);
        #1;
        eg = (cur >= 0 && cur < N) ? (N'(1) << cur) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("host_gnt", 32'(host_gnt), 32'(cur == HOST_ID));
        chk("busy", 32'(busy), 32'((cur != -1) || gap));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("onehot", 32'($onehot0(gnt)), 32'd1);
        chk("excl", 32'((gnt != '0) && host_gnt), 32'd0);
        bad = ((prev_gnt != '0) && (gnt != '0) && (gnt != prev_gnt))
           || ((prev_gnt != '0) && host_gnt) || (prev_hg && (gnt != '0));
        chk("turn_gap", 32'(bad), 32'd0);
        prev_gnt = gnt;
        prev_hg  = host_gnt;
    endtask

    initial begin
        logic [N-1:0] rq_r;
        logic [N-1:0] ls_r;
        logic         hr_r;
        logic         rs_r;
        clk = 1'b0; rst = 1'b1; req = '0; last = '0; host_req = 1'b0;
        prev_gnt = '0; prev_hg = 1'b0;
        cur = -1; gap = 0; ptr = 0; beats = 0; m_owner = 0;

        // Reset, then 8'h05: PE0 first, release by last, dead cycle, then PE2.
        step(1, '0, '0, 0);
        step(1, '0, '0, 0);
        step(0, 8'h05, '0, 0);
        chk("r29_g0", 32'(gnt), 32'h01);
        step(0, 8'h05, 8'h01, 0);
        chk("r29_turn", 32'(gnt), 32'h00);
        step(0, 8'h04, '0, 0);
        chk("r29_g2", 32'(gnt), 32'h04);
        step(0, 8'h00, '0, 0);

        // All PEs requesting forever: 32-beat rotation with one dead cycle between grants.
        step(1, '0, '0, 0);
        for (int c = 0; c < 9 * (MAX + 1) + 2; c++) step(0, 8'hFF, '0, 0);

        // Host arrives mid-grant of PE3; PE4 must come before PE3 afterwards.
        step(1, '0, '0, 0);
        for (int c = 0; c < 5; c++) step(0, 8'h08, '0, 0);
        chk("r31_pe3", 32'(gnt), 32'h08);
        for (int c = 0; c < 40; c++) step(0, 8'h18, '0, 1);
        chk("r31_host", 32'(host_gnt), 32'd1);
        step(0, 8'h18, '0, 0);
        step(0, 8'h18, '0, 0);
        chk("r31_pe4", 32'(gnt), 32'h10);

        // PE6 owner hands off: wraps to PE1, or goes to PE7 when it requests.
        step(1, '0, '0, 0);
        step(0, 8'h40, '0, 0);
        step(0, 8'h42, 8'h40, 0);
        step(0, 8'h02, '0, 0);
        chk("r32_wrap", 32'(gnt), 32'h02);
        step(1, '0, '0, 0);
        step(0, 8'h40, '0, 0);
        step(0, 8'hC2, 8'h40, 0);
        step(0, 8'h82, '0, 0);
        chk("r32_pe7", 32'(gnt), 32'h80);

        // Reset during PE5 grant, then 8'h21 starts from PE0.
        step(1, '0, '0, 0);
        step(0, 8'h20, '0, 0);
        step(0, 8'h20, '0, 0);
        step(1, 8'h20, '0, 0);
        chk("r33_rst", 32'({gnt, host_gnt, owner, busy}), 32'd0);
        step(0, 8'h21, '0, 0);
        chk("r33_pe0", 32'(gnt), 32'h01);

        // Random traffic against the model.
        rq_r = '0; hr_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rq_r[i]) rq_r[i] = ($urandom_range(3, 0) == 0);
                else          rq_r[i] = ($urandom_range(15, 0) != 0);
                ls_r[i] = ($urandom_range(7, 0) == 0);
            end
            if ($urandom_range(19, 0) == 0) hr_r = ~hr_r;
            rs_r = ($urandom_range(199, 0) == 0);
            step(rs_r, rq_r, ls_r, hr_r);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
